// File: rtl/bi_dir_pkg.sv
// Shared types and helpers for the bi-directional serial driver.
// Macro SERIAL_PARITY_EN appends an even-parity bit to every frame.
package bi_dir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    function automatic int unsigned frame_len(input int unsigned width);
`ifdef SERIAL_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/bi_dir_bit_counter.sv
// Frame bit counter: counts enabled cycles 0..LAST, wraps to 0 after LAST,
// and flags the terminal count.
module bi_dir_bit_counter #(
    parameter int unsigned CW   = 3,
    parameter int unsigned LAST = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] count;

    assign tc = (count == CW'(LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/bi_dir_serial_driver.sv
// Serializes a handshaked parallel word onto serial_right/serial_left for the
// downstream shift register. Macro SERIAL_PARITY_EN adds a trailing parity bit.
module bi_dir_serial_driver
    import bi_dir_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             sel,
    output logic             serial_right,
    output logic             serial_left,
    output logic             shift_en,
    output logic             busy,
    output logic             done
);

    localparam int unsigned FRAME = frame_len(WIDTH);
    localparam int unsigned CW    = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic             accept;
    logic             last_bit;
    logic             data_bit;
    logic             frame_bit;
`ifdef SERIAL_PARITY_EN
    logic             parity;
`endif

    assign accept = in_valid & in_ready;

    bi_dir_bit_counter #(
        .CW   (CW),
        .LAST (FRAME - 1)
    ) u_counter (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (shift_en),
        .tc  (last_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The word shifts toward whichever end is presented, so the outgoing bit
    // is always at a fixed position for the latched direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            sel   <= DIR_RIGHT;
        end else if (accept) begin
            shreg <= in_data;
            sel   <= in_dir;
        end else if (shift_en) begin
            if (sel == DIR_LEFT) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
        end
    end

    assign data_bit = (sel == DIR_LEFT) ? shreg[WIDTH-1] : shreg[0];

`ifdef SERIAL_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (accept) begin
            parity <= ^in_data;
        end
    end

    // The terminal count cycle carries the parity bit instead of data.
    assign frame_bit = last_bit ? parity : data_bit;
`else
    assign frame_bit = data_bit;
`endif

    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        shift_en     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        serial_right = 1'b0;
        serial_left  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift_en     = 1'b1;
                busy         = 1'b1;
                serial_right = (sel == DIR_RIGHT) & frame_bit;
                serial_left  = (sel == DIR_LEFT) & frame_bit;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bi_dir_serial_driver.sv
// Self-checking bench for bi_dir_serial_driver with a behavioural downstream
// 4-bit bi-directional register; honours SERIAL_PARITY_EN when defined.
module tb_bi_dir_serial_driver;

    localparam int W = 4;
`ifdef SERIAL_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_dir;
    logic         sel;
    logic         serial_right;
    logic         serial_left;
    logic         shift_en;
    logic         busy;
    logic         done;

    logic [W-1:0] q;
    int           cyc = 0;
    int           last_accept = -1;
    int           total = 0;
    int           bad = 0;

    bi_dir_serial_driver #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_dir       (in_dir),
        .sel          (sel),
        .serial_right (serial_right),
        .serial_left  (serial_left),
        .shift_en     (shift_en),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream register: right shift enters at q[MSB], left shift at q[0].
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (shift_en) begin
            if (sel) q <= {q[W-2:0], serial_left};
            else     q <= {serial_right, q[W-1:1]};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, in_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_shen"}, shift_en, 0);
        check({tag, "_sr"}, serial_right, 0);
        check({tag, "_sl"}, serial_left, 0);
    endtask

    // Caller is #1 after a posedge. Presents one frame and checks every cycle
    // up to the first IDLE cycle after done.
    task automatic run_frame(input logic [W-1:0] data, input logic dir, input bit keep_valid,
                             input logic [W-1:0] next_data, input int spacing_exp);
        int    waited;
        logic  exp_bit;
        in_valid = 1'b1;
        in_data  = data;
        in_dir   = dir;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (in_ready !== 1'b1) begin
            check("ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (spacing_exp > 0) check("b2b_spacing", cyc - last_accept, spacing_exp);
        last_accept = cyc;
        #1;
        for (int i = 0; i < FLEN; i++) begin
            // Inputs are ignored while shifting; drive junk or the next word.
            if (keep_valid) begin
                in_valid = 1'b1;
                in_data  = next_data;
            end else begin
                in_valid = 1'($urandom);
                in_data  = W'($urandom);
            end
            in_dir = 1'($urandom);
            if (i < W) exp_bit = dir ? data[W-1-i] : data[i];
            else       exp_bit = ^data;
            check("shift_en", shift_en, 1);
            check("busy_shift", busy, 1);
            check("ready_shift", in_ready, 0);
            check("done_shift", done, 0);
            check("sel", sel, dir);
            check(dir ? "serial_left" : "serial_right", dir ? serial_left : serial_right, exp_bit);
            check(dir ? "idle_line_r" : "idle_line_l", dir ? serial_right : serial_left, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = keep_valid ? next_data : W'($urandom);
        check("done_pulse", done, 1);
        check("busy_done", busy, 1);
        check("ready_done", in_ready, 0);
        check("shen_done", shift_en, 0);
`ifndef SERIAL_PARITY_EN
        check("downstream_q", q, data);
`endif
        @(posedge clk); #1;
        in_valid = keep_valid;
        check_idle_outputs("post");
        check("sel_hold", sel, dir);
    endtask

    initial begin
        logic [W-1:0] d;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_dir   = 1'b0;
        #1;
        check_idle_outputs("reset");
        check("reset_sel", sel, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("after_rst");
        check("after_rst_sel", sel, 0);

        run_frame(4'b1011, 1'b0, 0, '0, 0);
        run_frame(4'b1011, 1'b1, 0, '0, 0);

        // Back-to-back with in_valid held: 0110 then 1001.
        run_frame(4'b0110, 1'b0, 1, 4'b1001, 0);
        run_frame(4'b1001, 1'b0, 0, '0, FLEN + 2);

        // Reset in the middle of a frame.
        in_valid = 1'b1;
        in_data  = 4'b1111;
        in_dir   = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        check("midrst_sel", sel, 0);
        check("midrst_q", q, 0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < FLEN + 3; i++) begin
            @(posedge clk); #1;
            check("midrst_no_done", done, 0);
            check("midrst_no_busy", busy, 0);
        end
        run_frame(4'b0001, 1'($urandom), 0, '0, 0);

        // Randomized frames with random idle gaps.
        for (int n = 0; n < 24; n++) begin
            d = W'($urandom);
            run_frame(d, 1'($urandom), 0, '0, 0);
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                @(posedge clk); #1;
                check_idle_outputs("gap");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1);
    end

endmodule
